// File: rtl/vend_pkg.sv
// Shared types for the vending ledger: FSM states, command codes, coin values, slot pricing.
package vend_pkg;

  typedef enum logic [2:0] {
    S_SELECT  = 3'd0,
    S_QTY     = 3'd1,
    S_PAY     = 3'd2,
    S_VEND    = 3'd3,
    S_RESTOCK = 3'd4
  } state_t;

  localparam logic [2:0] CMD_SEL_NEXT = 3'd0;
  localparam logic [2:0] CMD_SEL_PREV = 3'd1;
  localparam logic [2:0] CMD_QTY_INC  = 3'd2;
  localparam logic [2:0] CMD_QTY_DEC  = 3'd3;
  localparam logic [2:0] CMD_CONFIRM  = 3'd4;
  localparam logic [2:0] CMD_CANCEL   = 3'd5;
  localparam logic [2:0] CMD_RESTOCK  = 3'd6;
  localparam logic [2:0] CMD_CLEAR    = 3'd7;

  function automatic logic [3:0] coin_value(input logic [1:0] coin);
    case (coin)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd5;
      default: return 4'd10;
    endcase
  endfunction

  function automatic int price_of(input int base, input int step, input int idx);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/vend_slot_bank.sv
// Per-slot stock and sold counters: one combinational read port, one registered write port.
// Latency: write visible on read port the cycle after wr_en/clr; no backpressure.
module vend_slot_bank #(
  parameter int N_ITEMS = 4,
  parameter int CNT_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [$clog2(N_ITEMS)-1:0]   wr_id,
  input  logic [CNT_W-1:0]             wr_stock,
  input  logic [CNT_W-1:0]             wr_sold,
  input  logic [$clog2(N_ITEMS)-1:0]   rd_id,
  output logic [CNT_W-1:0]             rd_stock,
  output logic [CNT_W-1:0]             rd_sold
);

  logic [CNT_W-1:0] stock [N_ITEMS];
  logic [CNT_W-1:0] sold  [N_ITEMS];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        stock[i] <= '0;
        sold[i]  <= '0;
      end
    end else if (wr_en) begin
      stock[wr_id] <= wr_stock;
      sold[wr_id]  <= wr_sold;
    end
  end

  assign rd_stock = stock[rd_id];
  assign rd_sold  = sold[rd_id];

endmodule

// File: rtl/vend_ledger.sv
// Vending ledger FSM: slot select, quantity, payment, vend and restock; SALES_LOG_EN adds a revenue counter.
// Latency: state/outputs registered one cycle after command; total lags qty/id by one cycle; no backpressure.
module vend_ledger
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int CNT_W      = 4,
  parameter int MONEY_W    = 7,
  parameter int PRICE_BASE = 3,
  parameter int PRICE_STEP = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  input  logic [2:0]                  cmd,
  input  logic                        coin_valid,
  input  logic [1:0]                  coin,
  output logic [$clog2(N_ITEMS)-1:0]  id,
  output logic [CNT_W-1:0]            qty,
  output logic [CNT_W-1:0]            stock_cur,
  output logic [MONEY_W-1:0]          total,
  output logic [MONEY_W-1:0]          paid,
  output logic [MONEY_W-1:0]          change,
  output logic [2:0]                  state,
  output logic                        sold_out,
  output logic                        vend_valid,
  output logic [CNT_W-1:0]            vend_qty,
`ifdef SALES_LOG_EN
  output logic [15:0]                 revenue,
`endif
  output logic                        err
);

  localparam int ID_W = $clog2(N_ITEMS);
  localparam int TW   = MONEY_W + CNT_W;
  localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(N_ITEMS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [MONEY_W-1:0] MONEY_MAX = '1;

  state_t             st, st_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic [CNT_W-1:0]   qty_nxt, rd_stock, rd_sold, wr_stock, wr_sold;
  logic [MONEY_W-1:0] paid_nxt, change_nxt, pay_sum, total_nxt;
  logic               err_nxt, wr_en, clr;
  logic [MONEY_W:0]   coin_sum;
  logic [CNT_W:0]     sold_sum;
  logic [TW-1:0]      price_w, prod;

  vend_slot_bank #(.N_ITEMS(N_ITEMS), .CNT_W(CNT_W)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_id    (id),
    .wr_stock (wr_stock),
    .wr_sold  (wr_sold),
    .rd_id    (id),
    .rd_stock (rd_stock),
    .rd_sold  (rd_sold)
  );

  assign stock_cur  = rd_stock;
  assign sold_out   = (rd_stock == '0);
  assign vend_valid = (st == S_VEND);
  assign vend_qty   = vend_valid ? qty : '0;
  assign state      = st;

  // A coin arriving with a CANCEL is counted before the refund is taken.
  assign coin_sum = {1'b0, paid} + (MONEY_W + 1)'(coin_value(coin));
  assign pay_sum  = !coin_valid ? paid :
                    (coin_sum[MONEY_W] ? MONEY_MAX : coin_sum[MONEY_W-1:0]);
  assign sold_sum = {1'b0, rd_sold} + {1'b0, qty};

  assign price_w   = TW'(price_of(PRICE_BASE, PRICE_STEP, int'(id)));
  assign prod      = TW'(qty) * price_w;
  assign total_nxt = (prod > TW'(MONEY_MAX)) ? MONEY_MAX : prod[MONEY_W-1:0];

  always_comb begin
    st_nxt     = st;
    id_nxt     = id;
    qty_nxt    = qty;
    paid_nxt   = paid;
    change_nxt = change;
    err_nxt    = 1'b0;
    wr_en      = 1'b0;
    wr_stock   = rd_stock;
    wr_sold    = rd_sold;
    clr        = 1'b0;

    if (coin_valid && st != S_PAY) err_nxt = 1'b1;
    if (cmd_valid && cmd == CMD_CLEAR && st != S_SELECT) err_nxt = 1'b1;

    case (st)
      S_SELECT: if (cmd_valid) begin
        case (cmd)
          CMD_SEL_NEXT: id_nxt = (id == ID_LAST) ? '0 : id + 1'b1;
          CMD_SEL_PREV: id_nxt = (id == '0) ? ID_LAST : id - 1'b1;
          CMD_CONFIRM: begin
            if (rd_stock != '0) begin
              st_nxt     = S_QTY;
              qty_nxt    = CNT_W'(1);
              change_nxt = '0;
            end else begin
              err_nxt = 1'b1;
            end
          end
          CMD_RESTOCK: begin
            st_nxt  = S_RESTOCK;
            qty_nxt = '0;
          end
          CMD_CLEAR: clr = 1'b1;
          default: ;
        endcase
      end
      S_QTY: if (cmd_valid) begin
        case (cmd)
          CMD_QTY_INC: if (qty < rd_stock) qty_nxt = qty + 1'b1;
          CMD_QTY_DEC: if (qty > CNT_W'(1)) qty_nxt = qty - 1'b1;
          CMD_CONFIRM: st_nxt = S_PAY;
          CMD_CANCEL: begin
            st_nxt  = S_SELECT;
            qty_nxt = '0;
          end
          default: ;
        endcase
      end
      S_PAY: begin
        paid_nxt = pay_sum;
        // An explicit CANCEL wins over a purchase that just became fully paid.
        if (cmd_valid && cmd == CMD_CANCEL) begin
          st_nxt     = S_SELECT;
          change_nxt = pay_sum;
          paid_nxt   = '0;
          qty_nxt    = '0;
        end else if (paid >= total) begin
          st_nxt     = S_VEND;
          change_nxt = pay_sum - total;
        end
      end
      S_VEND: begin
        wr_en    = 1'b1;
        wr_stock = rd_stock - qty;
        wr_sold  = sold_sum[CNT_W] ? CNT_MAX : sold_sum[CNT_W-1:0];
        st_nxt   = S_SELECT;
        qty_nxt  = '0;
        paid_nxt = '0;
      end
      S_RESTOCK: if (cmd_valid) begin
        case (cmd)
          CMD_QTY_INC: if (qty < CNT_MAX - rd_stock) qty_nxt = qty + 1'b1;
          CMD_CONFIRM: begin
            wr_en    = 1'b1;
            wr_stock = rd_stock + qty;
            st_nxt   = S_SELECT;
            qty_nxt  = '0;
          end
          CMD_CANCEL: begin
            st_nxt  = S_SELECT;
            qty_nxt = '0;
          end
          default: ;
        endcase
      end
      default: st_nxt = S_SELECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_SELECT;
      id     <= '0;
      qty    <= '0;
      paid   <= '0;
      total  <= '0;
      change <= '0;
      err    <= 1'b0;
    end else begin
      st     <= st_nxt;
      id     <= id_nxt;
      qty    <= qty_nxt;
      paid   <= paid_nxt;
      total  <= total_nxt;
      change <= change_nxt;
      err    <= err_nxt;
    end
  end

`ifdef SALES_LOG_EN
  logic [16:0] rev_sum;
  assign rev_sum = {1'b0, revenue} + 17'(total);

  always_ff @(posedge clk) begin
    if (rst || clr) revenue <= '0;
    else if (st == S_VEND) revenue <= rev_sum[16] ? 16'hFFFF : rev_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_vend_ledger.sv
// Bench for vend_ledger: directed scenarios plus random commands/coins against a cycle-level ledger model.
module tb_vend_ledger;

  localparam int N = 4, CMAX = 15, MMAX = 127, PB = 3, PS = 1;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, coin_valid;
  logic [2:0] cmd;
  logic [1:0] coin;
  logic [1:0] id;
  logic [3:0] qty, stock_cur, vend_qty;
  logic [6:0] total, paid, change;
  logic [2:0] state;
  logic       sold_out, vend_valid, err;
`ifdef SALES_LOG_EN
  logic [15:0] revenue;
`endif

  int n_vec = 0, n_bad = 0;

  // reference model state
  int m_st, m_id, m_qty, m_paid, m_total, m_chg, m_err, m_rev;
  int m_stock [N];
  int m_sold  [N];

  vend_ledger dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .coin_valid (coin_valid),
    .coin       (coin),
    .id         (id),
    .qty        (qty),
    .stock_cur  (stock_cur),
    .total      (total),
    .paid       (paid),
    .change     (change),
    .state      (state),
    .sold_out   (sold_out),
    .vend_valid (vend_valid),
    .vend_qty   (vend_qty),
`ifdef SALES_LOG_EN
    .revenue    (revenue),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int coin_units(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 5;
      default: return 10;
    endcase
  endfunction

  // One clock of the ledger rules; total follows the pre-edge qty and id.
  function automatic void model_step(input bit r, input bit cv, input int c, input bit kv, input int k);
    int o_qty, o_id, pay, e;
    if (r) begin
      m_st = 0; m_id = 0; m_qty = 0; m_paid = 0; m_total = 0; m_chg = 0; m_err = 0; m_rev = 0;
      for (int i = 0; i < N; i++) begin m_stock[i] = 0; m_sold[i] = 0; end
      return;
    end
    o_qty = m_qty; o_id = m_id; e = 0;
    if (kv && m_st != 2) e = 1;
    if (cv && c == 7 && m_st != 0) e = 1;
    case (m_st)
      0: if (cv) begin
        if (c == 0) m_id = (m_id + 1) % N;
        else if (c == 1) m_id = (m_id + N - 1) % N;
        else if (c == 4) begin
          if (m_stock[m_id] > 0) begin m_st = 1; m_qty = 1; m_chg = 0; end
          else e = 1;
        end else if (c == 6) begin m_st = 4; m_qty = 0; end
        else if (c == 7) begin
          for (int i = 0; i < N; i++) begin m_stock[i] = 0; m_sold[i] = 0; end
          m_rev = 0;
        end
      end
      1: if (cv) begin
        if (c == 2 && m_qty < m_stock[m_id]) m_qty++;
        else if (c == 3 && m_qty > 1) m_qty--;
        else if (c == 4) m_st = 2;
        else if (c == 5) begin m_st = 0; m_qty = 0; end
      end
      2: begin
        pay = kv ? min2(m_paid + coin_units(k), MMAX) : m_paid;
        if (cv && c == 5) begin
          m_chg = pay; m_paid = 0; m_qty = 0; m_st = 0;
        end else begin
          if (m_paid >= m_total) begin m_st = 3; m_chg = pay - m_total; end
          m_paid = pay;
        end
      end
      3: begin
        m_stock[m_id] -= m_qty;
        m_sold[m_id] = min2(m_sold[m_id] + m_qty, CMAX);
        m_rev = min2(m_rev + m_total, 65535);
        m_st = 0; m_qty = 0; m_paid = 0;
      end
      default: if (cv) begin
        if (c == 2 && m_qty < CMAX - m_stock[m_id]) m_qty++;
        else if (c == 4) begin m_stock[m_id] += m_qty; m_st = 0; m_qty = 0; end
        else if (c == 5) begin m_st = 0; m_qty = 0; end
      end
    endcase
    m_total = min2(o_qty * (PB + o_id * PS), MMAX);
    m_err = e;
  endfunction

  task automatic check_all();
    chk("state", int'(state), m_st);
    chk("id", int'(id), m_id);
    chk("qty", int'(qty), m_qty);
    chk("stock_cur", int'(stock_cur), m_stock[m_id]);
    chk("sold_out", int'(sold_out), int'(m_stock[m_id] == 0));
    chk("total", int'(total), m_total);
    chk("paid", int'(paid), m_paid);
    chk("change", int'(change), m_chg);
    chk("vend_valid", int'(vend_valid), int'(m_st == 3));
    chk("vend_qty", int'(vend_qty), (m_st == 3) ? m_qty : 0);
    chk("err", int'(err), m_err);
`ifdef SALES_LOG_EN
    chk("revenue", int'(revenue), m_rev);
`endif
  endtask

  task automatic step(input bit r, input bit cv, input int c, input bit kv, input int k);
    rst = r; cmd_valid = cv; cmd = 3'(c); coin_valid = kv; coin = 2'(k);
    @(posedge clk);
    model_step(r, cv, c, kv, k);
    #1;
    check_all();
  endtask

  task automatic cmdc(input int c);  step(0, 1, c, 0, 0); endtask
  task automatic coinc(input int k); step(0, 0, 0, 1, k); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; coin_valid = 1'b0; coin = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_state", int'(state), 0);
    chk("rst_total", int'(total), 0);
    chk("rst_stock", int'(stock_cur), 0);

    // restock slot 0 and walk the id ring
    cmdc(6); repeat (5) cmdc(2); cmdc(4);
    repeat (4) cmdc(0);
    chk("wrap_id", int'(id), 0);
    chk("restock_s0", int'(stock_cur), 5);
    cmdc(1);
    chk("prev_id", int'(id), 3);

    // slot 1 with 3 in stock, quantity clamps, 10+5 pays 12
    cmdc(0); cmdc(0); cmdc(6); repeat (3) cmdc(2); cmdc(4);
    chk("stock_s1", int'(stock_cur), 3);
    cmdc(4); repeat (5) cmdc(2); idle(1);
    chk("qty_clamp", int'(qty), 3);
    chk("total12", int'(total), 12);
    cmdc(4); coinc(3); coinc(2);
    chk("paid15", int'(paid), 15);
    idle(1);
    chk("vend_state", int'(state), 3);
    chk("vend_qty3", int'(vend_qty), 3);
    chk("change3", int'(change), 3);
    idle(1);
    chk("s1_empty", int'(stock_cur), 0);
    chk("sold_out1", int'(sold_out), 1);
    chk("change_hold", int'(change), 3);

    // cancel in PAY with a simultaneous coin refunds it too
    cmdc(1); cmdc(4);
    chk("change_clr", int'(change), 0);
    cmdc(2); cmdc(4);
    chk("total6", int'(total), 6);
    coinc(1); step(0, 1, 5, 1, 2);
    chk("refund7", int'(change), 7);
    chk("cancel_state", int'(state), 0);
    chk("cancel_stock", int'(stock_cur), 5);

    // error pulses
    cmdc(0); cmdc(4);
    chk("empty_err", int'(err), 1);
    chk("empty_state", int'(state), 0);
    idle(1);
    chk("err_pulse", int'(err), 0);
    coinc(1);
    chk("coin_err", int'(err), 1);
    chk("coin_paid0", int'(paid), 0);

    // restock headroom near full, then reset mid-payment
    cmdc(0); cmdc(6); repeat (14) cmdc(2); cmdc(4);
    chk("stock14", int'(stock_cur), 14);
    cmdc(6); repeat (3) cmdc(2);
    chk("restock_cap", int'(qty), 1);
    cmdc(4);
    chk("stock15", int'(stock_cur), 15);
    cmdc(4); cmdc(2); cmdc(4); coinc(2); coinc(1); coinc(1);
    chk("paid9", int'(paid), 9);
    step(1, 1, 5, 1, 3);
    chk("rst_pay_state", int'(state), 0);
    chk("rst_pay_id", int'(id), 0);
    chk("rst_pay_paid", int'(paid), 0);
    chk("rst_pay_change", int'(change), 0);
    chk("rst_pay_err", int'(err), 0);
    chk("rst_pay_stock", int'(stock_cur), 0);

    // CLEAR outside SELECT is refused
    cmdc(6); cmdc(2); cmdc(2); cmdc(4); cmdc(4); cmdc(7);
    chk("clr_qty_err", int'(err), 1);
    chk("clr_qty_stock", int'(stock_cur), 2);
    cmdc(5); cmdc(7);
    chk("clr_stock", int'(stock_cur), 0);

    // two sales of 12 and 5
    cmdc(0); cmdc(6); repeat (3) cmdc(2); cmdc(4);
    cmdc(4); cmdc(2); cmdc(2); cmdc(4); coinc(3); coinc(1); idle(2);
    cmdc(0); cmdc(6); cmdc(2); cmdc(4); cmdc(4); cmdc(4); coinc(2); idle(2);
    chk("sale2_stock", int'(stock_cur), 0);
`ifdef SALES_LOG_EN
    chk("revenue17", int'(revenue), 17);
    cmdc(7);
    chk("revenue_clr", int'(revenue), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      int c;
      c = int'($urandom_range(0, 7));
      if (c == 7 && $urandom_range(0, 3) != 0) c = 2;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, c,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_ledger.md
VEND_LEDGER -- requirements
Module: vend_ledger

Interface
REQ-001 SHALL have parameter N_ITEMS, default 4: number of product slots (2..16).
REQ-002 SHALL have parameter CNT_W, default 4: width of per-slot stock and quantity counts.
REQ-003 SHALL have parameter MONEY_W, default 7: width of paid, total and change values.
REQ-004 SHALL have parameters PRICE_BASE, default 3, and PRICE_STEP, default 1: price of slot i is PRICE_BASE + i*PRICE_STEP.
REQ-005 SHALL have one clock; reset is synchronous and active-high. Ports: clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-006 SHALL have cmd_valid (in, 1) qualifying cmd (in, 3): SEL_NEXT=0, SEL_PREV=1, QTY_INC=2, QTY_DEC=3, CONFIRM=4, CANCEL=5, RESTOCK=6, CLEAR=7.
REQ-007 SHALL have coin_valid (in, 1) qualifying coin (in, 2): 0=1, 1=2, 2=5, 3=10 units.
REQ-008 SHALL have outputs: id (clog2(N_ITEMS)), qty (CNT_W), stock_cur (CNT_W), total (MONEY_W), paid (MONEY_W), change (MONEY_W), state (3), sold_out (1), vend_valid (1), vend_qty (CNT_W), err (1).

Function
REQ-009 SHALL implement states SELECT=0, QTY=1, PAY=2, VEND=3, RESTOCK=4; all updates on the rising edge of clk.
REQ-010 In SELECT: SEL_NEXT/SEL_PREV SHALL change id by +1/-1 modulo N_ITEMS; CONFIRM SHALL go to QTY with qty=1 if stock_cur>0, else stay and pulse err; RESTOCK SHALL go to RESTOCK with qty=0.
REQ-011 In QTY: QTY_INC SHALL increment qty only while qty<stock_cur; QTY_DEC SHALL decrement only while qty>1; CONFIRM SHALL go to PAY; CANCEL SHALL return to SELECT with qty=0.
REQ-012 total SHALL be a registered qty*price(id), valid one cycle after any qty or id change, computed at MONEY_W+CNT_W bits and saturated to all-ones.
REQ-013 In PAY: each coin_valid SHALL add its value to paid, saturating at 2^MONEY_W-1; coin_valid outside PAY SHALL be ignored and pulse err.
REQ-014 In PAY: when paid>=total, the next cycle SHALL enter VEND with change=paid-total; CANCEL SHALL return to SELECT with change=paid, then paid=0.
REQ-015 VEND SHALL last exactly one cycle: vend_valid=1, vend_qty=qty, stock[id]-=qty, sold[id]+=qty (saturating); then SELECT with qty=0 and paid=0; change holds until the next CONFIRM out of SELECT.
REQ-016 In RESTOCK: QTY_INC SHALL increment qty only while qty<(2^CNT_W-1)-stock_cur; CONFIRM SHALL add qty to stock[id] and return to SELECT; CANCEL SHALL return without change.
REQ-017 CLEAR SHALL be accepted only in SELECT, zeroing all stock and sold counters; elsewhere it SHALL be ignored and pulse err.
REQ-018 cmd and coin valid in the same cycle in PAY: coin SHALL be processed first; a CANCEL in that cycle refunds paid including that coin.
REQ-019 Unlisted cmd in any state SHALL be ignored, with no err.
REQ-020 stock_cur SHALL equal stock[id] combinationally; sold_out SHALL be 1 when stock_cur==0.
REQ-021 err SHALL be a single-cycle pulse.

Reset
REQ-022 On rst: state=SELECT, id=0, qty=0, paid=0, total=0, change=0, vend_valid=0, vend_qty=0, err=0, all stock[] and sold[] = 0; rst SHALL override any command in that cycle, including mid-PAY (coins are lost, no refund).

Configuration
REQ-023 With SALES_LOG_EN defined: SHALL add output revenue (16 bits), incremented by total on each VEND, saturating, cleared by rst and CLEAR; without it, no revenue port or register exists.

Structure
REQ-024 Package vend_pkg SHALL hold the state enum, cmd encodings, the coin-value table and the price function.
REQ-025 Sub-module vend_slot_bank SHALL hold the N_ITEMS stock/sold counter arrays with a read port on id and one write port for VEND, RESTOCK and CLEAR.

Verification
REQ-026 Reset, RESTOCK id0 with qty 5, SEL_NEXT x4 -> stock[0]=5, id wraps to 0; SEL_PREV -> id=3.
REQ-027 id1 with stock 3: QTY_INC x5 -> qty=3, total=12; coins 10, 5 -> VEND, change=3, stock[1]=0, sold_out=1.
REQ-028 PAY with total 6, coin 2, then CANCEL together with coin 5 -> change=7, state SELECT, stock unchanged.
REQ-029 CONFIRM on empty slot -> err pulse, state SELECT; coin in SELECT -> err, paid=0.
REQ-030 Stock 14 at CNT_W=4, RESTOCK QTY_INC x3 -> qty=1, stock=15; rst asserted in PAY with paid=9 -> all outputs at reset values next cycle.
REQ-031 SALES_LOG_EN build, two vends of total 12 and 5 -> revenue=17; CLEAR -> revenue=0.
